// File: rtl/axis_frame_checker_pkg.sv
// Shared types and default sizing for the AXI-Stream frame checker.
package axis_frame_checker_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_MAX_FRAME   = 4096;
   localparam int FRAME_CNT_WIDTH = 16;

   // Beat counter must be able to hold MAX_FRAME itself, not just MAX_FRAME-1.
   function automatic int cnt_width(input int max_frame);
      return $clog2(max_frame + 1);
   endfunction

   localparam int DEF_CNT_WIDTH = cnt_width(DEF_MAX_FRAME);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECV   = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

endpackage

// File: rtl/axis_frame_stats_acc.sv
// Per-frame beat counter, modulo-2^DATA_WIDTH sum and sticky error flags.
// Optional strobe checking is enabled by defining AXIS_FRAME_CHECKER_STRB_CHECK_EN.
module axis_frame_stats_acc #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 13,
   parameter int MAX_FRAME  = 4096
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_clear,
   input  logic                    i_accept,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic [DATA_WIDTH/8-1:0] i_strb,
   input  logic                    i_last,
   output logic [CNT_WIDTH-1:0]    o_count,
   output logic [DATA_WIDTH-1:0]   o_sum,
   output logic                    o_overflow,
   output logic                    o_strb_err,
   output logic                    o_at_limit
);

   localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(MAX_FRAME - 1);

   logic [CNT_WIDTH-1:0]  r_count;
   logic [DATA_WIDTH-1:0] r_sum;
   logic                  r_overflow;

   // The next accepted beat would be the MAX_FRAME-th one.
   assign o_at_limit = (r_count == LIMIT_M1);

   // Count beats, accumulate data (carry dropped), flag a frame cut at MAX_FRAME.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count    <= '0;
         r_sum      <= '0;
         r_overflow <= 1'b0;
      end else if (i_accept) begin
         r_count <= r_count + 1'b1;
         r_sum   <= r_sum + i_data;
         if (!i_last && o_at_limit)
            r_overflow <= 1'b1;
      end
   end

   assign o_count    = r_count;
   assign o_sum      = r_sum;
   assign o_overflow = r_overflow;

`ifdef AXIS_FRAME_CHECKER_STRB_CHECK_EN
   logic r_strb_err;

   // Any accepted beat with a partial strobe marks the whole frame.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear)
         r_strb_err <= 1'b0;
      else if (i_accept && (i_strb != '1))
         r_strb_err <= 1'b1;
   end

   assign o_strb_err = r_strb_err;
`else
   logic w_unused_strb;
   assign w_unused_strb = ^i_strb;
   assign o_strb_err    = 1'b0;
`endif

endmodule

// File: rtl/axis_frame_checker.sv
// End-of-chain AXI-Stream frame checker: counts beats, sums data, checks length
// and holds a status record until acknowledged.
// Optional strobe checking: define AXIS_FRAME_CHECKER_STRB_CHECK_EN.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   ST_IDLE   | tready low; waits for cfg_enable, latches expected length
//   ST_RECV   | accepts beats until tlast or MAX_FRAME beats
//   ST_REPORT | tready low; loads status one cycle in, waits for stat_ack
module axis_frame_checker
   import axis_frame_checker_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int MAX_FRAME       = DEF_MAX_FRAME,
   parameter int CNT_WIDTH       = cnt_width(MAX_FRAME),
   parameter int THROTTLE_PERIOD = 0
) (
   input  logic                       s04_axis_aclk,
   input  logic                       s04_axis_areset,
   input  logic [DATA_WIDTH-1:0]      s04_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]    s04_axis_tstrb,
   input  logic                       s04_axis_tvalid,
   input  logic                       s04_axis_tlast,
   output logic                       s04_axis_tready,
   input  logic                       cfg_enable,
   input  logic [CNT_WIDTH-1:0]       cfg_expected_len,
   output logic                       stat_valid,
   input  logic                       stat_ack,
   output logic [CNT_WIDTH-1:0]       stat_word_count,
   output logic [DATA_WIDTH-1:0]      stat_sum,
   output logic                       stat_len_err,
   output logic                       stat_overflow,
   output logic                       stat_strb_err,
   output logic [FRAME_CNT_WIDTH-1:0] stat_frame_count
);

   localparam int THR_DIV   = (THROTTLE_PERIOD > 0) ? THROTTLE_PERIOD : 1;
   localparam int THR_WIDTH = (THR_DIV > 1) ? $clog2(THR_DIV) : 1;
   localparam logic [THR_WIDTH-1:0] THR_LAST = THR_WIDTH'(THR_DIV - 1);

   state_t                     r_state;
   logic                       r_loaded;
   logic [CNT_WIDTH-1:0]       r_exp_len;
   logic [THR_WIDTH-1:0]       r_thr;
   logic                       r_stat_valid;
   logic [CNT_WIDTH-1:0]       r_stat_count;
   logic [DATA_WIDTH-1:0]      r_stat_sum;
   logic                       r_stat_len_err;
   logic                       r_stat_overflow;
   logic                       r_stat_strb_err;
   logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;

   logic                  w_throttle;
   logic                  w_tready;
   logic                  w_accept;
   logic                  w_clear;
   logic                  w_end;
   logic                  w_at_limit;
   logic [CNT_WIDTH-1:0]  w_count;
   logic [DATA_WIDTH-1:0] w_sum;
   logic                  w_overflow;
   logic                  w_strb_err;

   assign w_throttle = (THROTTLE_PERIOD > 0) && (r_thr == THR_LAST);
   assign w_tready   = (r_state == ST_RECV) && !w_throttle;
   assign w_accept   = s04_axis_tvalid && w_tready;
   assign w_clear    = (r_state == ST_IDLE) && cfg_enable;
   assign w_end      = w_accept && (s04_axis_tlast || w_at_limit);

   axis_frame_stats_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .MAX_FRAME  (MAX_FRAME)
   ) u_acc (
      .i_clk      (s04_axis_aclk),
      .i_rst      (s04_axis_areset),
      .i_clear    (w_clear),
      .i_accept   (w_accept),
      .i_data     (s04_axis_tdata),
      .i_strb     (s04_axis_tstrb),
      .i_last     (s04_axis_tlast),
      .o_count    (w_count),
      .o_sum      (w_sum),
      .o_overflow (w_overflow),
      .o_strb_err (w_strb_err),
      .o_at_limit (w_at_limit)
   );

   // Frame sequencing, throttle timing and the held status record.
   always_ff @(posedge s04_axis_aclk) begin
      if (s04_axis_areset) begin
         r_state         <= ST_IDLE;
         r_loaded        <= 1'b0;
         r_exp_len       <= '0;
         r_thr           <= '0;
         r_stat_valid    <= 1'b0;
         r_stat_count    <= '0;
         r_stat_sum      <= '0;
         r_stat_len_err  <= 1'b0;
         r_stat_overflow <= 1'b0;
         r_stat_strb_err <= 1'b0;
         r_frame_cnt     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_thr    <= '0;
               r_loaded <= 1'b0;
               if (cfg_enable) begin
                  r_exp_len <= cfg_expected_len;
                  r_state   <= ST_RECV;
               end
            end
            ST_RECV: begin
               if (THROTTLE_PERIOD > 0)
                  r_thr <= w_throttle ? '0 : r_thr + 1'b1;
               if (w_end)
                  r_state <= ST_REPORT;
            end
            ST_REPORT: begin
               if (!r_loaded) begin
                  r_loaded        <= 1'b1;
                  r_stat_valid    <= 1'b1;
                  r_stat_count    <= w_count;
                  r_stat_sum      <= w_sum;
                  r_stat_overflow <= w_overflow;
                  r_stat_strb_err <= w_strb_err;
                  r_stat_len_err  <= w_overflow || w_strb_err || (w_count != r_exp_len);
                  r_frame_cnt     <= r_frame_cnt + 1'b1;
               end else if (r_stat_valid && stat_ack) begin
                  r_stat_valid <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign s04_axis_tready  = w_tready;
   assign stat_valid       = r_stat_valid;
   assign stat_word_count  = r_stat_count;
   assign stat_sum         = r_stat_sum;
   assign stat_len_err     = r_stat_len_err;
   assign stat_overflow    = r_stat_overflow;
   assign stat_strb_err    = r_stat_strb_err;
   assign stat_frame_count = r_frame_cnt;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Self-checking bench for axis_frame_checker: frame table, hand-written corner
// sequences, randomized frames against a frame-level reference model, and a
// throttled instance.
`timescale 1ns/1ps
module tb_axis_frame_checker;

   localparam int DW  = 32;
   localparam int MF  = 16;
   localparam int CW  = 5;
   localparam int TCW = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [DW-1:0] tdata;
   logic [3:0]    tstrb;
   logic          tvalid, tlast, tready;
   logic          cfg_enable;
   logic [CW-1:0] cfg_expected_len;
   logic          stat_valid, stat_ack;
   logic [CW-1:0] stat_word_count;
   logic [DW-1:0] stat_sum;
   logic          stat_len_err, stat_overflow, stat_strb_err;
   logic [15:0]   stat_frame_count;

   logic           t_valid, t_last, t_ready, t_en, t_ack, t_sv;
   logic [DW-1:0]  t_data, t_sum;
   logic [TCW-1:0] t_exp, t_cnt;
   logic           t_lerr, t_ovf, t_serr;
   logic [15:0]    t_fc;

   axis_frame_checker #(.DATA_WIDTH(DW), .MAX_FRAME(MF), .CNT_WIDTH(CW), .THROTTLE_PERIOD(0)) u_dut (
      .s04_axis_aclk(clk), .s04_axis_areset(rst), .s04_axis_tdata(tdata), .s04_axis_tstrb(tstrb),
      .s04_axis_tvalid(tvalid), .s04_axis_tlast(tlast), .s04_axis_tready(tready),
      .cfg_enable(cfg_enable), .cfg_expected_len(cfg_expected_len),
      .stat_valid(stat_valid), .stat_ack(stat_ack), .stat_word_count(stat_word_count),
      .stat_sum(stat_sum), .stat_len_err(stat_len_err), .stat_overflow(stat_overflow),
      .stat_strb_err(stat_strb_err), .stat_frame_count(stat_frame_count));

   axis_frame_checker #(.DATA_WIDTH(DW), .MAX_FRAME(4096), .CNT_WIDTH(TCW), .THROTTLE_PERIOD(4)) u_thr (
      .s04_axis_aclk(clk), .s04_axis_areset(rst), .s04_axis_tdata(t_data), .s04_axis_tstrb(4'hF),
      .s04_axis_tvalid(t_valid), .s04_axis_tlast(t_last), .s04_axis_tready(t_ready),
      .cfg_enable(t_en), .cfg_expected_len(t_exp),
      .stat_valid(t_sv), .stat_ack(t_ack), .stat_word_count(t_cnt),
      .stat_sum(t_sum), .stat_len_err(t_lerr), .stat_overflow(t_ovf),
      .stat_strb_err(t_serr), .stat_frame_count(t_fc));

   typedef struct {
      logic [DW-1:0] d;
      logic [3:0]    s;
      logic          l;
   } beat_t;

   typedef struct {
      int            len;
      int            exp_len;
      logic [DW-1:0] base;
      logic [DW-1:0] step;
      int            e_cnt;
      logic [DW-1:0] e_sum;
      bit            e_err;
      bit            e_ovf;
   } vec_t;

   beat_t       q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_fc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame the source intends to send; beats past MAX_FRAME never get accepted.
   task automatic build(input int len, input logic [DW-1:0] base, input logic [DW-1:0] step, input bit rnd_strb);
      beat_t b;
      int n;
      q.delete();
      n = (len > MF) ? MF : len;
      for (int i = 0; i < n; i++) begin
         b.d = base + step * DW'(i);
         b.s = (rnd_strb && $urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
         b.l = (i == len - 1);
         q.push_back(b);
      end
   endtask

   // Reference: status record implied by the beats actually consumed.
   task automatic model(input int exp_len, output int cnt, output logic [DW-1:0] sum,
                        output bit ovf, output bit serr, output bit lerr);
      cnt  = q.size();
      sum  = '0;
      serr = 1'b0;
      foreach (q[i]) begin
         sum = sum + q[i].d;
         if (q[i].s != 4'hF) serr = 1'b1;
      end
`ifndef AXIS_FRAME_CHECKER_STRB_CHECK_EN
      serr = 1'b0;
`endif
      ovf  = !q[cnt-1].l;
      lerr = ovf || serr || (cnt != exp_len);
   endtask

   task automatic send_frame(input int exp_len, input bit gaps);
      bit rdy;
      int cyc;
      cfg_expected_len = CW'(exp_len);
      cfg_enable       = 1'b1;
      for (int i = 0; i < q.size(); i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               tvalid = 1'b0;
               tdata  = $urandom;
               tlast  = 1'($urandom_range(0, 1));
               tstrb  = 4'($urandom);
               @(posedge clk); #1;
            end
         end
         tvalid = 1'b1;
         tdata  = q[i].d;
         tstrb  = q[i].s;
         tlast  = q[i].l;
         cyc    = 0;
         do begin
            @(negedge clk);
            rdy = tready;
            @(posedge clk); #1;
            cyc++;
         end while (!rdy && cyc < 64);
         if (!rdy) begin
            chk("beat_timeout", 64'd0, 64'd1);
            tvalid = 1'b0;
            return;
         end
         if (i == 0) begin
            cfg_enable       = 1'($urandom_range(0, 1));
            cfg_expected_len = CW'($urandom);
         end
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   // Called one cycle after the ending beat was accepted.
   task automatic expect_report(input int cnt, input logic [DW-1:0] sum, input bit ovf,
                                input bit serr, input bit lerr, input int hold, input bit early_ack);
      if (early_ack) stat_ack = 1'b1;
      @(negedge clk);
      chk("valid_not_early", 64'(stat_valid), 64'd0);
      chk("tready_report", 64'(tready), 64'd0);
      @(posedge clk); #1;
      stat_ack = 1'b0;
      exp_fc   = exp_fc + 16'd1;
      @(negedge clk);
      chk("valid_latency", 64'(stat_valid), 64'd1);
      chk("word_count", 64'(stat_word_count), 64'(cnt));
      chk("sum", 64'(stat_sum), 64'(sum));
      chk("overflow", 64'(stat_overflow), 64'(ovf));
      chk("strb_err", 64'(stat_strb_err), 64'(serr));
      chk("len_err", 64'(stat_len_err), 64'(lerr));
      chk("frame_count", 64'(stat_frame_count), 64'(exp_fc));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("hold_valid", 64'(stat_valid), 64'd1);
         chk("hold_count", 64'(stat_word_count), 64'(cnt));
         chk("hold_sum", 64'(stat_sum), 64'(sum));
         chk("hold_tready", 64'(tready), 64'd0);
      end
      stat_ack = 1'b1;
      @(posedge clk); #1;
      stat_ack   = 1'b0;
      cfg_enable = 1'b0;
      @(negedge clk);
      chk("ack_clears_valid", 64'(stat_valid), 64'd0);
      chk("idle_tready", 64'(tready), 64'd0);
   endtask

   task automatic run_frame(input int exp_len, input bit gaps, input int hold, input bit early);
      int c;
      logic [DW-1:0] s;
      bit o, se, le;
      model(exp_len, c, s, o, se, le);
      send_frame(exp_len, gaps);
      expect_report(c, s, o, se, le, hold, early);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t vt[6];
      int   c, len;
      logic [DW-1:0] s;
      bit   o, se, le;
      int   k, beats;
      logic [DW-1:0] tsum;
      bit   acc;

      vt[0] = '{8,  8,  32'h1,        32'h1, 8,  32'd36,        1'b0, 1'b0};
      vt[1] = '{3,  4,  32'hFFFFFFFF, 32'h0, 3,  32'hFFFFFFFD,  1'b1, 1'b0};
      vt[2] = '{20, 16, 32'h10,       32'h1, 16, 32'h178,       1'b1, 1'b1};
      vt[3] = '{1,  1,  32'hDEADBEEF, 32'h0, 1,  32'hDEADBEEF,  1'b0, 1'b0};
      vt[4] = '{16, 16, 32'h80000000, 32'h0, 16, 32'h0,         1'b0, 1'b0};
      vt[5] = '{2,  5,  32'h5,        32'h3, 2,  32'd13,        1'b1, 1'b0};

      rst = 1'b1; tdata = '0; tstrb = 4'hF; tvalid = 1'b0; tlast = 1'b0;
      cfg_enable = 1'b0; cfg_expected_len = '0; stat_ack = 1'b0; exp_fc = '0;
      t_valid = 1'b0; t_last = 1'b0; t_data = '0; t_en = 1'b0; t_exp = '0; t_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_tready", 64'(tready), 64'd0);
      chk("rst_valid", 64'(stat_valid), 64'd0);
      chk("rst_count", 64'(stat_word_count), 64'd0);
      chk("rst_sum", 64'(stat_sum), 64'd0);
      chk("rst_len_err", 64'(stat_len_err), 64'd0);
      chk("rst_overflow", 64'(stat_overflow), 64'd0);
      chk("rst_frame_count", 64'(stat_frame_count), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Table of frames with hand-derived results.
      for (int v = 0; v < 6; v++) begin
         build(vt[v].len, vt[v].base, vt[v].step, 1'b0);
         send_frame(vt[v].exp_len, 1'b0);
         expect_report(vt[v].e_cnt, vt[v].e_sum, vt[v].e_ovf, 1'b0, vt[v].e_err, 1, 1'b0);
      end

      // Overflow with the source still pushing: record held 10 cycles, beat 17 not lost.
      build(20, 32'h100, 32'h1, 1'b0);
      model(16, c, s, o, se, le);
      send_frame(16, 1'b0);
      tvalid = 1'b1; tdata = 32'h110; tlast = 1'b0; tstrb = 4'hF;
      expect_report(c, s, o, se, le, 10, 1'b0);
      build(4, 32'h110, 32'h1, 1'b0);
      run_frame(4, 1'b0, 0, 1'b0);

      // Partial strobe on one beat.
      build(3, 32'h7, 32'h11, 1'b0);
      q[1].s = 4'b0111;
      run_frame(3, 1'b0, 0, 1'b0);

      // Randomized frames: lengths across the MAX_FRAME boundary, gaps, early acks.
      for (int r = 0; r < 40; r++) begin
         len = $urandom_range(1, 20);
         build(len, $urandom, $urandom, 1'b1);
         run_frame(($urandom_range(0, 1) == 0) ? q.size() : $urandom_range(1, 20),
                   1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Throttled instance: tready low on every 4th RECV cycle.
      t_exp = 13'd12; t_en = 1'b1; t_valid = 1'b1; t_data = 32'd1; t_last = 1'b0;
      @(posedge clk); #1;
      k = 0; beats = 0; tsum = '0;
      while (beats < 12 && k < 40) begin
         @(negedge clk);
         chk("thr_tready", 64'(t_ready), 64'((k % 4) != 3));
         acc = t_ready;
         @(posedge clk); #1;
         k++;
         if (acc) begin
            tsum   = tsum + t_data;
            beats++;
            t_en   = 1'b0;
            t_data = DW'(beats + 1);
            t_last = (beats == 11);
         end
      end
      t_valid = 1'b0; t_last = 1'b0;
      chk("thr_cycles", 64'(k), 64'd15);
      @(posedge clk); #1;
      @(negedge clk);
      chk("thr_valid", 64'(t_sv), 64'd1);
      chk("thr_count", 64'(t_cnt), 64'd12);
      chk("thr_sum", 64'(t_sum), 64'(tsum));
      chk("thr_sum_const", 64'(t_sum), 64'd78);
      chk("thr_len_err", 64'(t_lerr), 64'd0);
      chk("thr_overflow", 64'(t_ovf), 64'd0);
      chk("thr_strb_err", 64'(t_serr), 64'd0);
      chk("thr_frame_count", 64'(t_fc), 64'd1);
      t_ack = 1'b1;
      @(posedge clk); #1;
      t_ack = 1'b0;
      @(negedge clk);
      chk("thr_ack", 64'(t_sv), 64'd0);

      // Reset in the middle of a frame discards it and restarts frame counting.
      build(7, 32'h20, 32'h1, 1'b0);
      while (q.size() > 5) void'(q.pop_back());
      send_frame(7, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; exp_fc = '0; cfg_enable = 1'b0;
      @(negedge clk);
      chk("midrst_tready", 64'(tready), 64'd0);
      chk("midrst_valid", 64'(stat_valid), 64'd0);
      chk("midrst_frame_count", 64'(stat_frame_count), 64'd0);
      build(2, 32'h55, 32'h1, 1'b0);
      run_frame(2, 1'b0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
